// File: rtl/aes_enc_pipe_if.sv
// ---------------------------------------------------------------------------
// aes_enc_pipe_if
// Handshake bundle for the AES-128 pipelined encryption core.
//   key channel : key_valid/key_ready/key_in, plus key_loaded status
//   input       : in_valid/in_ready/in_data/in_tag
//   output      : out_valid/out_ready/out_data/out_tag
//   control     : flush (discard in-flight blocks), busy (status)
// master = the block driving keys/plaintext and consuming ciphertext.
// slave  = the encryption core.
// ---------------------------------------------------------------------------
interface aes_enc_pipe_if #(
    parameter int TAG_W = 4
);
    logic             key_valid;
    logic             key_ready;
    logic [127:0]     key_in;
    logic             key_loaded;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
    logic             busy;

    modport master (
        output key_valid, key_in, in_valid, in_data, in_tag, out_ready, flush,
        input  key_ready, key_loaded, in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  key_valid, key_in, in_valid, in_data, in_tag, out_ready, flush,
        output key_ready, key_loaded, in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/aes_enc_pipe.sv
// ---------------------------------------------------------------------------
// aes_enc_pipe
// AES-128 encryption core with ROUNDS_PER_STAGE AES rounds per pipeline stage
// (NSTAGE = 10 / ROUNDS_PER_STAGE; legal values 1, 2, 5, 10).
// The cipher key is expanded serially (one round key per cycle) into a round
// key register file; blocks then stream at up to one per cycle with a
// sideband tag that travels unmodified alongside each block.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : aes_enc_pipe_if.slave (key, input and output handshakes, flush,
//           key_loaded and busy status)
// Helper modules in this file: aes_sbox, aes_round, key_expansion (all
// purely combinational).
// Byte 0 of every 128-bit word sits in [127:120]; AES state is column-major.
// ---------------------------------------------------------------------------

// S-box computed as GF(2^8) inverse (x^254) followed by the affine transform,
// which keeps the file free of a 256-entry table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i[2:0]]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    always_comb begin : p_sbox
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = a;
        inv = 8'h01;
        // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// One AES round: SubBytes, ShiftRows, MixColumns (skipped when LAST),
// AddRoundKey.
module aes_round #(
    parameter bit LAST = 1'b0
) (
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    output logic [127:0] state_out
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [127:0] sb_v;
    logic [127:0] sr_v;
    logic [127:0] mc_v;

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        // byte gi = row (gi%4), column (gi/4); row r rotates left by r columns
        localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
        aes_sbox u_sbox (
            .a (state_in[127-8*gi -: 8]),
            .s (sb_v[127-8*gi -: 8])
        );
        assign sr_v[127-8*gi -: 8]      = sb_v[127-8*SRC -: 8];
        assign state_out[127-8*gi -: 8] = mc_v[127-8*gi -: 8] ^ rk[127-8*gi -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_v[127-32*gi -: 8];
        assign a1 = sr_v[119-32*gi -: 8];
        assign a2 = sr_v[111-32*gi -: 8];
        assign a3 = sr_v[103-32*gi -: 8];
        if (LAST) begin : g_nomix
            assign mc_v[127-32*gi -: 32] = {a0, a1, a2, a3};
        end else begin : g_mix
            assign mc_v[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
    end
endmodule

// One step of the AES-128 key schedule: previous round key -> next round key.
module key_expansion (
    input  logic [127:0] key_prev,
    input  logic [7:0]   rcon,
    output logic [127:0] key_next
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_prev;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot[31-8*gi -: 8]),
            .s (sub[31-8*gi -: 8])
        );
    end

    assign temp     = sub ^ {rcon, 24'h000000};
    assign n0       = w0 ^ temp;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};
endmodule

module aes_enc_pipe #(
    parameter int ROUNDS_PER_STAGE = 1,
    parameter int TAG_W            = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    aes_enc_pipe_if.slave bus
);
    localparam int NSTAGE = 10 / ROUNDS_PER_STAGE;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_READY
    } key_state_t;

    key_state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [10:0][127:0] rk_reg;
    logic [10:0][127:0] rk_next;
    logic [127:0]       rk_prev;
    logic [127:0]       rk_new;
    logic [3:0]         rk_idx;
    logic [7:0]         rcon;

    logic key_ready, key_loaded, key_hs;
    logic pipe_busy, adv, in_ready, accept;

    // Bit/entry NSTAGE is the output register; 0..NSTAGE-1 are the stages.
    logic [NSTAGE:0]             st_valid_reg;
    logic [NSTAGE:0][127:0]      st_data_reg;
    logic [NSTAGE:0][127:0]      st_data_next;
    logic [NSTAGE:0][TAG_W-1:0]  st_tag_reg;

    // ---------------- key FSM ----------------
    assign pipe_busy = |st_valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        key_loaded = (state_reg == KS_READY);
        // A new key may only land once nothing in flight still needs the old one
        key_ready  = (state_reg == KS_IDLE) | ((state_reg == KS_READY) & ~pipe_busy);
        key_hs     = bus.key_valid & key_ready;
        case (state_reg)
            KS_IDLE: begin
                if (key_hs) begin
                    state_next = KS_EXPAND;
                    cnt_next   = 4'd1;
                end
            end
            KS_EXPAND: begin
                if (cnt_reg == 4'd10) begin
                    state_next = KS_READY;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            KS_READY: begin
                if (key_hs) begin
                    state_next = KS_EXPAND;
                    cnt_next   = 4'd1;
                end
            end
            default: begin
                state_next = KS_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= KS_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- serial key expansion ----------------
    always_comb begin
        case (cnt_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rk_idx  = cnt_reg - 4'd1;
    assign rk_prev = rk_reg[rk_idx];

    key_expansion u_kexp (
        .key_prev (rk_prev),
        .rcon     (rcon),
        .key_next (rk_new)
    );

    for (genvar gi = 0; gi <= 10; gi++) begin : g_rk
        if (gi == 0) begin : g_rk0
            // key_in is captured here, so the source may change after handshake
            assign rk_next[gi] = key_hs ? bus.key_in : rk_reg[gi];
        end else begin : g_rkn
            assign rk_next[gi] = ((state_reg == KS_EXPAND) && (cnt_reg == 4'(gi)))
                                 ? rk_new : rk_reg[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_reg <= '0;
        end else begin
            rk_reg <= rk_next;
        end
    end

    // ---------------- datapath pipeline ----------------
    // Global stall: every stage moves together, no bubble collapsing.
    assign adv      = ~st_valid_reg[NSTAGE] | bus.out_ready;
    assign in_ready = key_loaded & adv & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;

    assign st_data_next[0] = bus.in_data ^ rk_reg[0];

    for (genvar gs = 0; gs < NSTAGE; gs++) begin : g_stage
        logic [127:0] chain [0:ROUNDS_PER_STAGE];
        assign chain[0] = st_data_reg[gs];
        for (genvar gr = 0; gr < ROUNDS_PER_STAGE; gr++) begin : g_rnd
            aes_round #(
                .LAST ((gs * ROUNDS_PER_STAGE + gr + 1) == 10)
            ) u_round (
                .state_in  (chain[gr]),
                .rk        (rk_reg[gs * ROUNDS_PER_STAGE + gr + 1]),
                .state_out (chain[gr+1])
            );
        end
        assign st_data_next[gs+1] = chain[ROUNDS_PER_STAGE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid_reg <= '0;
            st_data_reg  <= '0;
            st_tag_reg   <= '0;
        end else begin
            // flush wins over advance and also drops a stalled output block
            if (bus.flush) begin
                st_valid_reg <= '0;
            end else if (adv) begin
                st_valid_reg <= {st_valid_reg[NSTAGE-1:0], accept};
            end
            if (adv) begin
                st_data_reg <= st_data_next;
                st_tag_reg  <= {st_tag_reg[NSTAGE-1:0], bus.in_tag};
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.key_ready  = key_ready;
    assign bus.key_loaded = key_loaded;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = st_valid_reg[NSTAGE];
    assign bus.out_data   = st_data_reg[NSTAGE];
    assign bus.out_tag    = st_tag_reg[NSTAGE];
    assign bus.busy       = (state_reg == KS_EXPAND) | pipe_busy;
endmodule
